// File: rtl/usb_rx_decoder.sv
// USB full-speed receive front end: synchronizes D+/D-, recovers bit timing,
// decodes NRZI, detects SYNC/EOP, removes stuffed bits and assembles bytes.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int HALF         = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       sync_found,
    output logic       eop,
    output logic       rx_error,
    output logic       rx_active
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP1,
        S_EOP2,
        S_WAIT
    } state_t;

    logic          dp_meta, dp_sync, dp_last;
    logic          dm_meta, dm_sync, dm_last;
    logic [CW-1:0] cnt, cnt_now;
    logic          line_chg, sample;
    logic          is_j, is_k, is_se0, is_jk, nrzi_bit;

    state_t        state, state_n;
    logic          prev_j, prev_j_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [2:0]    ones_cnt, ones_cnt_n;
    logic [7:0]    shift_reg, shift_reg_n;
    logic          se0_seen, se0_seen_n;
    logic [2:0]    j_run, j_run_n;
    logic [7:0]    rx_data_n;
    logic          valid_n, sync_n, eop_n, err_n;
    logic          to_wait;

    // Lines idle at J, so the synchronizers come out of reset at (1,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dp_last <= 1'b1;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
            dm_last <= 1'b0;
        end else begin
            dp_meta <= d_plus;
            dp_sync <= dp_meta;
            dp_last <= dp_sync;
            dm_meta <= d_minus;
            dm_sync <= dm_meta;
            dm_last <= dm_sync;
        end
    end

    // An edge forces the timer to zero in the same cycle, so sampling lands HALF cycles after it.
    assign line_chg = (dp_sync != dp_last) || (dm_sync != dm_last);
    assign cnt_now  = line_chg ? '0 : cnt;
    assign sample   = (cnt_now == CNT_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_now == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_now + CW'(1);
        end
    end

    assign is_j     = dp_sync & ~dm_sync;
    assign is_k     = ~dp_sync & dm_sync;
    assign is_se0   = ~dp_sync & ~dm_sync;
    assign is_jk    = dp_sync ^ dm_sync;
    assign nrzi_bit = (dp_sync == prev_j);

    assign rx_active = (state == S_SYNC) || (state == S_DATA) ||
                       (state == S_EOP1) || (state == S_EOP2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            prev_j        <= 1'b1;
            bit_cnt       <= '0;
            ones_cnt      <= '0;
            shift_reg     <= '0;
            se0_seen      <= 1'b0;
            j_run         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            sync_found    <= 1'b0;
            eop           <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            state         <= state_n;
            prev_j        <= prev_j_n;
            bit_cnt       <= bit_cnt_n;
            ones_cnt      <= ones_cnt_n;
            shift_reg     <= shift_reg_n;
            se0_seen      <= se0_seen_n;
            j_run         <= j_run_n;
            rx_data       <= rx_data_n;
            rx_data_valid <= valid_n;
            sync_found    <= sync_n;
            eop           <= eop_n;
            rx_error      <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        prev_j_n    = prev_j;
        bit_cnt_n   = bit_cnt;
        ones_cnt_n  = ones_cnt;
        shift_reg_n = shift_reg;
        se0_seen_n  = se0_seen;
        j_run_n     = j_run;
        rx_data_n   = rx_data;
        valid_n     = 1'b0;
        sync_n      = 1'b0;
        eop_n       = 1'b0;
        err_n       = 1'b0;
        to_wait     = 1'b0;

        if (sample) begin
            case (state)
                S_IDLE: begin
                    prev_j_n = 1'b1;
                    if (is_k) begin
                        state_n   = S_SYNC;
                        prev_j_n  = 1'b0;
                        bit_cnt_n = 3'd1;
                    end
                end

                // SYNC is seven zeros then a one; any deviation aborts immediately.
                S_SYNC: begin
                    if (is_jk) begin
                        prev_j_n = dp_sync;
                        if (nrzi_bit == (bit_cnt == 3'd7)) begin
                            if (bit_cnt == 3'd7) begin
                                sync_n     = 1'b1;
                                state_n    = S_DATA;
                                bit_cnt_n  = '0;
                                ones_cnt_n = '0;
                            end else begin
                                bit_cnt_n = bit_cnt + 3'd1;
                            end
                        end else begin
                            to_wait = 1'b1;
                        end
                    end else begin
                        to_wait = 1'b1;
                    end
                end

                S_DATA: begin
                    if (is_jk) begin
                        prev_j_n = dp_sync;
                        if (ones_cnt == 3'd6) begin
                            if (nrzi_bit) begin
                                to_wait = 1'b1;
                            end else begin
                                ones_cnt_n = '0;
                            end
                        end else begin
                            ones_cnt_n  = nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                            shift_reg_n = {nrzi_bit, shift_reg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                rx_data_n = {nrzi_bit, shift_reg[7:1]};
                                valid_n   = 1'b1;
                                bit_cnt_n = '0;
                            end else begin
                                bit_cnt_n = bit_cnt + 3'd1;
                            end
                        end
                    end else if (is_se0) begin
                        state_n = S_EOP1;
                    end else begin
                        to_wait = 1'b1;
                    end
                end

                S_EOP1: begin
                    if (is_se0) begin
                        state_n = S_EOP2;
                    end else begin
                        to_wait = 1'b1;
                    end
                end

                // A partial byte at EOP is dropped and flagged alongside eop.
                S_EOP2: begin
                    if (is_j) begin
                        eop_n    = 1'b1;
                        err_n    = (bit_cnt != 3'd0);
                        state_n  = S_IDLE;
                        prev_j_n = 1'b1;
                    end else begin
                        to_wait = 1'b1;
                    end
                end

                S_WAIT: begin
                    if (is_j) begin
                        if (se0_seen || (j_run == 3'd7)) begin
                            state_n    = S_IDLE;
                            prev_j_n   = 1'b1;
                            se0_seen_n = 1'b0;
                            j_run_n    = '0;
                        end else begin
                            j_run_n = j_run + 3'd1;
                        end
                    end else if (is_se0) begin
                        se0_seen_n = 1'b1;
                        j_run_n    = '0;
                    end else begin
                        se0_seen_n = 1'b0;
                        j_run_n    = '0;
                    end
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        if (to_wait) begin
            err_n      = 1'b1;
            state_n    = S_WAIT;
            se0_seen_n = 1'b0;
            j_run_n    = '0;
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: drives NRZI/stuffed packets on D+/D-
// and checks pulse counts and received bytes against hand-computed values.
module tb_usb_rx_decoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus;
    logic       d_minus;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       sync_found;
    logic       eop;
    logic       rx_error;
    logic       rx_active;

    usb_rx_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .sync_found   (sync_found),
        .eop          (eop),
        .rx_error     (rx_error),
        .rx_active    (rx_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int syncCnt = 0, validCnt = 0, eopCnt = 0, errCnt = 0, bothCnt = 0;
    logic [7:0] byteLog [64];
    int s0, v0, e0, r0, b0;

    bit lineJ;
    int onesRun;
    bit useShift;
    int shiftIdx;
    int shiftTab [6] = '{3, -3, 2, -3, 3, -1};

    // Pulse monitor samples on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (sync_found) syncCnt++;
        if (eop) eopCnt++;
        if (rx_error) errCnt++;
        if (eop && rx_error) bothCnt++;
        if (rx_data_valid) begin
            if (validCnt < 64) byteLog[validCnt] = rx_data;
            validCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dp, input logic dm, input int cycles);
        d_plus  = dp;
        d_minus = dm;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic snap();
        s0 = syncCnt;
        v0 = validCnt;
        e0 = eopCnt;
        r0 = errCnt;
        b0 = bothCnt;
    endtask

    // A zero toggles the line; with shifting on, each level run is stretched or shortened.
    task automatic sendNrzi(input bit b);
        int len;
        len = CPB;
        if (!b) begin
            lineJ = !lineJ;
            if (useShift) begin
                len = CPB + shiftTab[shiftIdx % 6];
                shiftIdx++;
            end
        end
        applyStimulus(lineJ, !lineJ, len);
    endtask

    task automatic sendDataBit(input bit b);
        sendNrzi(b);
        if (b) onesRun++;
        else onesRun = 0;
        if (onesRun == 6) begin
            sendNrzi(1'b0);
            onesRun = 0;
        end
    endtask

    task automatic sendSync();
        for (int i = 0; i < 7; i++) sendNrzi(1'b0);
        sendNrzi(1'b1);
        onesRun = 0;
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) sendDataBit(v[i]);
    endtask

    task automatic sendEop();
        applyStimulus(1'b0, 1'b0, 2 * CPB);
        applyStimulus(1'b1, 1'b0, CPB);
        lineJ = 1'b1;
    endtask

    task automatic idleBits(input int n);
        lineJ = 1'b1;
        applyStimulus(1'b1, 1'b0, n * CPB);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        d_plus   = 1'b1;
        d_minus  = 1'b0;
        lineJ    = 1'b1;
        onesRun  = 0;
        useShift = 1'b0;
        shiftIdx = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rx_data", 32'(rx_data), 32'h00);
        checkOutput("rst_rx_active", 32'(rx_active), 32'd0);
        checkOutput("rst_pulses", 32'({sync_found, rx_data_valid, eop, rx_error}), 32'd0);
        rst = 1'b0;

        $display("[TB] idle line");
        snap();
        idleBits(20);
        checkOutput("idle_sync", 32'(syncCnt - s0), 32'd0);
        checkOutput("idle_valid", 32'(validCnt - v0), 32'd0);
        checkOutput("idle_eop", 32'(eopCnt - e0), 32'd0);
        checkOutput("idle_err", 32'(errCnt - r0), 32'd0);
        checkOutput("idle_active", 32'(rx_active), 32'd0);

        $display("[TB] single byte 0xA5");
        snap();
        sendSync();
        checkOutput("a5_active_mid", 32'(rx_active), 32'd1);
        sendByte(8'hA5);
        sendEop();
        idleBits(2);
        checkOutput("a5_sync", 32'(syncCnt - s0), 32'd1);
        checkOutput("a5_valid", 32'(validCnt - v0), 32'd1);
        checkOutput("a5_byte", 32'(byteLog[v0]), 32'hA5);
        checkOutput("a5_eop", 32'(eopCnt - e0), 32'd1);
        checkOutput("a5_err", 32'(errCnt - r0), 32'd0);
        checkOutput("a5_active_after", 32'(rx_active), 32'd0);
        checkOutput("a5_rx_data_hold", 32'(rx_data), 32'hA5);

        $display("[TB] stuffed bytes 0xFF 0x7E");
        snap();
        sendSync();
        sendByte(8'hFF);
        sendByte(8'h7E);
        sendEop();
        idleBits(2);
        checkOutput("stuff_valid", 32'(validCnt - v0), 32'd2);
        checkOutput("stuff_byte0", 32'(byteLog[v0]), 32'hFF);
        checkOutput("stuff_byte1", 32'(byteLog[v0 + 1]), 32'h7E);
        checkOutput("stuff_err", 32'(errCnt - r0), 32'd0);
        checkOutput("stuff_eop", 32'(eopCnt - e0), 32'd1);

        $display("[TB] stuffing violation then recovery");
        snap();
        sendSync();
        for (int i = 0; i < 7; i++) sendNrzi(1'b1);
        checkOutput("viol_err", 32'(errCnt - r0), 32'd1);
        checkOutput("viol_valid", 32'(validCnt - v0), 32'd0);
        checkOutput("viol_active", 32'(rx_active), 32'd0);
        sendEop();
        idleBits(2);
        checkOutput("viol_no_eop", 32'(eopCnt - e0), 32'd0);
        checkOutput("viol_err_once", 32'(errCnt - r0), 32'd1);
        snap();
        sendSync();
        sendByte(8'h3C);
        sendEop();
        idleBits(2);
        checkOutput("recov_valid", 32'(validCnt - v0), 32'd1);
        checkOutput("recov_byte", 32'(byteLog[v0]), 32'h3C);
        checkOutput("recov_err", 32'(errCnt - r0), 32'd0);
        checkOutput("recov_eop", 32'(eopCnt - e0), 32'd1);

        $display("[TB] partial byte at EOP");
        snap();
        sendSync();
        sendByte(8'h5A);
        sendDataBit(1'b1);
        sendDataBit(1'b0);
        sendDataBit(1'b0);
        sendDataBit(1'b1);
        sendEop();
        idleBits(2);
        checkOutput("part_valid", 32'(validCnt - v0), 32'd1);
        checkOutput("part_byte", 32'(byteLog[v0]), 32'h5A);
        checkOutput("part_eop", 32'(eopCnt - e0), 32'd1);
        checkOutput("part_err", 32'(errCnt - r0), 32'd1);
        checkOutput("part_same_cycle", 32'(bothCnt - b0), 32'd1);

        $display("[TB] jittered edges then reset mid-packet");
        snap();
        useShift = 1'b1;
        shiftIdx = 0;
        sendSync();
        sendByte(8'hC3);
        sendDataBit(1'b1);
        sendDataBit(1'b0);
        sendDataBit(1'b0);
        sendDataBit(1'b0);
        useShift = 1'b0;
        checkOutput("jit_sync", 32'(syncCnt - s0), 32'd1);
        checkOutput("jit_valid", 32'(validCnt - v0), 32'd1);
        checkOutput("jit_byte", 32'(byteLog[v0]), 32'hC3);
        checkOutput("jit_err", 32'(errCnt - r0), 32'd0);
        checkOutput("jit_active", 32'(rx_active), 32'd1);
        rst     = 1'b1;
        lineJ   = 1'b1;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_rx_data", 32'(rx_data), 32'h00);
        checkOutput("mid_rst_active", 32'(rx_active), 32'd0);
        checkOutput("mid_rst_pulses", 32'({sync_found, rx_data_valid, eop, rx_error}), 32'd0);
        rst = 1'b0;
        snap();
        idleBits(20);
        checkOutput("post_rst_sync", 32'(syncCnt - s0), 32'd0);
        checkOutput("post_rst_valid", 32'(validCnt - v0), 32'd0);
        checkOutput("post_rst_eop", 32'(eopCnt - e0), 32'd0);
        checkOutput("post_rst_err", 32'(errCnt - r0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
